mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mult_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: arbitrates NUM_REQ requesters onto one shared multiplier.
// One operation in flight at a time: IDLE -> ISSUE -> WAIT -> RESPOND.
// Completion is timed by a latency counter loaded with MUL_LATENCY.
// Optional feature: define MULT_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the lowest-index requester wins.
module mult_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [16*NUM_REQ-1:0]  i_req_a,
    input  logic [16*NUM_REQ-1:0]  i_req_b,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [NUM_REQ-1:0]     o_rsp_valid,
    output logic [15:0]            o_rsp_product,
    output logic                   o_mul_enable,
    output logic [15:0]            o_mul_a,
    output logic [15:0]            o_mul_b,
    input  logic [15:0]            i_mul_product,
    output logic                   o_busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StRespond
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [IDX_W-1:0]   r_winner;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_mul_a;
    logic [15:0]        r_mul_b;
    logic [15:0]        r_rsp_product;

    logic [15:0]        w_req_a [NUM_REQ];
    logic [15:0]        w_req_b [NUM_REQ];
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic               w_accept;

    // Unpack the flat operand buses into per-requester words.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_a[i] = i_req_a[16*i +: 16];
            w_req_b[i] = i_req_b[16*i +: 16];
        end
    end

`ifdef MULT_ARB_ROUND_ROBIN_EN
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W:0]   w_sum;

    // Round-robin pick: first valid requester at or after the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
            if (w_sum >= NUM_REQ_W) begin
                w_sum = w_sum - NUM_REQ_W;
            end
            if (!w_found && i_req_valid[w_sum[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IDX_W-1:0];
            end
        end
    end

    // Pointer moves to one past the winner on every accept.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;
        end
    end
`else
    // Fixed priority pick: lowest-index valid requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req_valid[i]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(i);
            end
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and strobe outputs; requests are only looked at in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        o_req_ready  = '0;
        o_rsp_valid  = '0;
        o_mul_enable = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_accept     = 1'b1;
                    o_req_ready  = NUM_REQ'(1) << w_winner;
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                o_mul_enable = 1'b1;
                w_state_next = StWait;
            end
            StWait: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_next = StRespond;
                end
            end
            StRespond: begin
                o_rsp_valid  = NUM_REQ'(1) << r_winner;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: operand/winner capture, latency counter, result capture.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_winner      <= '0;
            r_cnt         <= '0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_rsp_product <= '0;
        end else begin
            if (w_accept) begin
                r_winner <= w_winner;
                r_mul_a  <= w_req_a[w_winner];
                r_mul_b  <= w_req_b[w_winner];
            end
            if (r_state == StIssue) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == StWait) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // Product is valid exactly when the counter hits 1.
            if (r_state == StWait && r_cnt == CNT_ONE) begin
                r_rsp_product <= i_mul_product;
            end
        end
    end

    assign o_mul_a       = r_mul_a;
    assign o_mul_b       = r_mul_b;
    assign o_rsp_product = r_rsp_product;
    assign o_busy        = (r_state != StIdle);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a latency-2 multiplier stub that returns A+B.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_product;
    logic        mul_enable;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] mul_product;
    logic        busy;

    int err_cnt = 0;
    int chk_cnt = 0;

    mult_arbiter #(
        .NUM_REQ     (4),
        .MUL_LATENCY (2)
    ) u_dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_req_valid   (req_valid),
        .i_req_a       (req_a),
        .i_req_b       (req_b),
        .o_req_ready   (req_ready),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_product (rsp_product),
        .o_mul_enable  (mul_enable),
        .o_mul_a       (mul_a),
        .o_mul_b       (mul_b),
        .i_mul_product (mul_product),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    // Multiplier stub: result is valid exactly 2 cycles after mul_enable, zero otherwise.
    logic [15:0] s1 = '0;
    logic [15:0] s2 = '0;
    always @(posedge clk) begin
        s1 <= mul_enable ? (mul_a + mul_b) : 16'h0000;
        s2 <= s1;
    end
    assign mul_product = s2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until a grant appears; waited counts negedges taken.
    task automatic wait_grant(output logic [3:0] gnt, output int waited);
        waited = 0;
        #1;
        while (req_ready == 4'b0000 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        gnt = req_ready;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [3:0] g;
    int         n;
    logic [3:0] exp_seq [5];
    int         rsp_seen;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready", {28'b0, req_ready}, 32'h0);
        check("rst_rsp_valid", {28'b0, rsp_valid}, 32'h0);
        check("rst_product", {16'b0, rsp_product}, 32'h0);
        check("rst_mul_en", {31'b0, mul_enable}, 32'h0);
        check("rst_mul_a", {16'b0, mul_a}, 32'h0);
        check("rst_mul_b", {16'b0, mul_b}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);

        // Single request on requester 1: 3 + 4 = 7
        @(negedge clk);
        req_valid = 4'b0010;
        req_a[31:16] = 16'h0003;
        req_b[31:16] = 16'h0004;
        #1;
        check("single_ready", {28'b0, req_ready}, 32'h2);
        @(negedge clk);
        req_valid = 4'b0000;
        check("single_issue_en", {31'b0, mul_enable}, 32'h1);
        check("single_mul_a", {16'b0, mul_a}, 32'h3);
        check("single_mul_b", {16'b0, mul_b}, 32'h4);
        @(negedge clk);
        check("single_en_pulse", {31'b0, mul_enable}, 32'h0);
        @(negedge clk);
        check("single_early_rsp", {28'b0, rsp_valid}, 32'h0);
        @(negedge clk);
        check("single_rsp_valid", {28'b0, rsp_valid}, 32'h2);
        check("single_product", {16'b0, rsp_product}, 32'h7);
        @(negedge clk);
        check("single_rsp_pulse", {28'b0, rsp_valid}, 32'h0);
        check("single_idle", {31'b0, busy}, 32'h0);
        check("single_hold", {16'b0, rsp_product}, 32'h7);

        // Stability: requester 0 operand changes during WAIT
        req_valid = 4'b0001;
        req_a[15:0] = 16'h0010;
        req_b[15:0] = 16'h0020;
        wait_grant(g, n);
        check("stab_ready", {28'b0, g}, 32'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        req_a[15:0] = 16'h1111;
        #1;
        check("stab_mul_a", {16'b0, mul_a}, 32'h0010);
        @(negedge clk);
        check("stab_mul_a2", {16'b0, mul_a}, 32'h0010);
        @(negedge clk);
        check("stab_rsp_valid", {28'b0, rsp_valid}, 32'h1);
        check("stab_product", {16'b0, rsp_product}, 32'h0030);
        wait_idle();

        // Highest requester, negative operand: -1 + 2 = 1
        @(negedge clk);
        req_valid = 4'b1000;
        req_a[63:48] = 16'hFFFF;
        req_b[63:48] = 16'h0002;
        wait_grant(g, n);
        check("neg_ready", {28'b0, g}, 32'h8);
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        check("neg_rsp_valid", {28'b0, rsp_valid}, 32'h8);
        check("neg_product", {16'b0, rsp_product}, 32'h0001);
        wait_idle();

        // Contention with requests held
`ifdef MULT_ARB_ROUND_ROBIN_EN
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        @(negedge clk);
        req_valid = 4'b1111;
`else
        exp_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        @(negedge clk);
        req_valid = 4'b0110;
`endif
        wait_grant(g, n);
        check("cont_gnt0", {28'b0, g}, {28'b0, exp_seq[0]});
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            wait_grant(g, n);
            check($sformatf("cont_gnt%0d", k), {28'b0, g}, {28'b0, exp_seq[k]});
            check($sformatf("cont_space%0d", k), n + 1, 32'd5);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        wait_idle();

        // Wrap: steer pointer to 3, then only requester 0 asks
        @(negedge clk);
        req_valid = 4'b0100;
        wait_grant(g, n);
        check("wrap_pre", {28'b0, g}, 32'h4);
        @(negedge clk);
        req_valid = 4'b0000;
        wait_idle();
        req_valid = 4'b0001;
        wait_grant(g, n);
        check("wrap_gnt0", {28'b0, g}, 32'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        wait_idle();
        req_valid = 4'b1111;
        wait_grant(g, n);
`ifdef MULT_ARB_ROUND_ROBIN_EN
        check("wrap_ptr_next", {28'b0, g}, 32'h2);
`else
        check("fixed_lowest", {28'b0, g}, 32'h1);
`endif
        @(negedge clk);
        req_valid = 4'b0000;
        wait_idle();

        // Reset during WAIT aborts the operation
        req_valid = 4'b0100;
        req_a[47:32] = 16'h0005;
        req_b[47:32] = 16'h0006;
        wait_grant(g, n);
        check("abort_ready", {28'b0, g}, 32'h4);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_rsp_valid", {28'b0, rsp_valid}, 32'h0);
        check("abort_mul_en", {31'b0, mul_enable}, 32'h0);
        check("abort_mul_a", {16'b0, mul_a}, 32'h0);
        check("abort_mul_b", {16'b0, mul_b}, 32'h0);
        check("abort_product", {16'b0, rsp_product}, 32'h0);
        check("abort_ready0", {28'b0, req_ready}, 32'h0);
        rsp_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid != 4'b0000) rsp_seen++;
        end
        check("abort_no_rsp", rsp_seen, 32'd0);

        // First grant after reset follows the reset pointer
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_valid = 4'b1111;
        wait_grant(g, n);
        check("post_rst_gnt", {28'b0, g}, 32'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
